top_k_stream_sorter: RTL and testbench

Parametrised streaming top-K selector, the successor to the cascaded top-K block in the top_k kernel. Consumes one INTEGER_SIZE-bit value per beat on an AXI4-Stream slave and keeps the K best values of the current frame in a sorted register array. On TLAST it emits the sorted set as one or more OUT_WIDTH-bit beats toward the TCP transmit path. Adds signed/unsigned and largest/smallest modes, per-lane valid flags for short frames, and a frame abort.

---
 rtl/top_k_pkg.sv | 39 +++
 rtl/top_k_slot.sv | 57 +++++
 rtl/top_k_stream_sorter.sv | 156 +++++++++++++++
 tb/tb_top_k_stream_sorter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_k_pkg.sv
// Shared types and helpers for the streaming top-K selector: FSM state, default geometry,
// a constant-friendly clog2 and the rank compare used by every slot.
package top_k_pkg;

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_e;

  localparam int DEF_TOP_K_NUM    = 16;
  localparam int DEF_INTEGER_SIZE = 32;
  localparam int DEF_OUT_WIDTH    = 512;
  localparam int LANES            = DEF_OUT_WIDTH / DEF_INTEGER_SIZE;
  localparam int NUM_BEATS        = (DEF_TOP_K_NUM * DEF_INTEGER_SIZE + DEF_OUT_WIDTH - 1) / DEF_OUT_WIDTH;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Extends a w-bit value held in the low bits to 64 bits, sign-filling when sgn is set.
  function automatic logic [63:0] widen(input logic [63:0] v, input int w, input logic sgn);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 64; i++) begin
      if (i >= w) r[i] = sgn & v[w-1];
    end
    return r;
  endfunction

  // True when a strictly outranks b.
  function automatic logic beats(input logic [63:0] a, input logic [63:0] b,
                                 input logic sgn, input logic desc);
    if (sgn) return desc ? ($signed(a) > $signed(b)) : ($signed(a) < $signed(b));
    return desc ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/top_k_slot.sv
// One rank of the sorted array: a value register plus valid flag. Combinational insert decision,
// one-cycle update; no backpressure of its own (the parent gates ins_en_i).
module top_k_slot
  import top_k_pkg::*;
#(
  parameter int W    = 32,
  parameter bit SGN  = 1'b0,
  parameter bit DESC = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] new_val_i,
  input  logic [W-1:0] up_val_i,
  input  logic         up_vld_i,
  input  logic         up_beat_i,
  input  logic         ins_en_i,
  input  logic         clr_i,
  output logic [W-1:0] val_o,
  output logic         vld_o,
  output logic         beat_o
);

  logic [W-1:0] val_q, val_d;
  logic         vld_q, vld_d;

  assign beat_o = !vld_q ||
                  beats(widen(64'(new_val_i), W, SGN), widen(64'(val_q), W, SGN), SGN, DESC);

  // Beaten slots below the insertion point inherit their upper neighbour; the first beaten slot takes the new value.
  always_comb begin
    val_d = val_q;
    vld_d = vld_q;
    if (ins_en_i && beat_o) begin
      if (up_beat_i) begin
        val_d = up_val_i;
        vld_d = up_vld_i;
      end else begin
        val_d = new_val_i;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      val_q <= '0;
      vld_q <= 1'b0;
    end else begin
      val_q <= val_d;
      vld_q <= vld_d;
    end
  end

  assign val_o = val_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/top_k_stream_sorter.sv
// Streaming top-K selector: result valid the cycle after the rx TLAST handshake, held until tx TREADY;
// rx_data_TREADY is low while emitting. `define TOP_K_FRAME_STATS_EN adds tx_frame_id / tx_frame_len.
module top_k_stream_sorter
  import top_k_pkg::*;
#(
  parameter int TOP_K_NUM    = DEF_TOP_K_NUM,
  parameter int INTEGER_SIZE = DEF_INTEGER_SIZE,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int SIGNED       = 0,
  parameter int DESCENDING   = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                rx_data_TVALID,
  output logic                                rx_data_TREADY,
  input  logic [INTEGER_SIZE-1:0]             rx_data_TDATA,
  input  logic                                rx_data_TLAST,
  output logic                                tx_data_TVALID,
  input  logic                                tx_data_TREADY,
  output logic [OUT_WIDTH-1:0]                tx_data_TDATA,
  output logic [OUT_WIDTH/INTEGER_SIZE-1:0]   tx_data_TKEEP,
  output logic                                tx_data_TLAST,
  output logic [clog2(TOP_K_NUM+1)-1:0]       tx_count
`ifdef TOP_K_FRAME_STATS_EN
  ,
  output logic [31:0]                         tx_frame_id,
  output logic [31:0]                         tx_frame_len
`endif
);

  localparam int W       = INTEGER_SIZE;
  localparam int N_LANES = OUT_WIDTH / INTEGER_SIZE;
  localparam int N_BEATS = (TOP_K_NUM * INTEGER_SIZE + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int PAD     = N_BEATS * N_LANES;
  localparam int CW      = clog2(TOP_K_NUM + 1);
  localparam int BW      = clog2(N_BEATS + 1);

  state_e          state_q;
  logic [BW-1:0]   beat_q;
  logic [CW-1:0]   count_q;
  logic            emit, acc_en, last_hs, slot_clr;

  logic [W-1:0]          slot_val [TOP_K_NUM];
  logic [W-1:0]          up_val   [TOP_K_NUM];
  logic [TOP_K_NUM-1:0]  slot_vld, slot_beat, up_vld, up_beat;

  assign emit           = (state_q == EMIT);
  assign rx_data_TREADY = !emit;
  assign acc_en         = !emit && rx_data_TVALID && !clear;
  assign last_hs        = emit && tx_data_TREADY && (beat_q == BW'(N_BEATS - 1));
  // No input is accepted while emitting, so the slot array itself holds the result until the last beat leaves.
  assign slot_clr       = (!emit && clear) || last_hs;

  for (genvar i = 0; i < TOP_K_NUM; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign up_val[i]  = '0;
      assign up_vld[i]  = 1'b0;
      assign up_beat[i] = 1'b0;
    end else begin : g_body
      assign up_val[i]  = slot_val[i-1];
      assign up_vld[i]  = slot_vld[i-1];
      assign up_beat[i] = slot_beat[i-1];
    end

    top_k_slot #(
      .W    (W),
      .SGN  (SIGNED != 0),
      .DESC (DESCENDING != 0)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .new_val_i (rx_data_TDATA),
      .up_val_i  (up_val[i]),
      .up_vld_i  (up_vld[i]),
      .up_beat_i (up_beat[i]),
      .ins_en_i  (acc_en),
      .clr_i     (slot_clr),
      .val_o     (slot_val[i]),
      .vld_o     (slot_vld[i]),
      .beat_o    (slot_beat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      beat_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (clear) begin
            count_q <= '0;
          end else if (rx_data_TVALID) begin
            // The beaten set is a suffix of the array, so the tail slot tells whether anything was inserted.
            if (slot_beat[TOP_K_NUM-1] && count_q < CW'(TOP_K_NUM)) count_q <= count_q + 1'b1;
            if (rx_data_TLAST) state_q <= EMIT;
          end
        end
        EMIT: begin
          if (tx_data_TREADY) begin
            if (beat_q == BW'(N_BEATS - 1)) begin
              beat_q  <= '0;
              count_q <= '0;
              state_q <= ACCUM;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  logic [PAD*W-1:0] pad_dat;
  logic [PAD-1:0]   pad_keep;

  for (genvar r = 0; r < PAD; r++) begin : g_rank
    if (r < TOP_K_NUM) begin : g_live
      assign pad_dat[r*W +: W] = slot_vld[r] ? slot_val[r] : '0;
      assign pad_keep[r]       = slot_vld[r];
    end else begin : g_unused
      assign pad_dat[r*W +: W] = '0;
      assign pad_keep[r]       = 1'b0;
    end
  end

  assign tx_data_TVALID = emit;
  assign tx_data_TDATA  = emit ? pad_dat[beat_q*OUT_WIDTH +: OUT_WIDTH] : '0;
  assign tx_data_TKEEP  = emit ? pad_keep[beat_q*N_LANES +: N_LANES] : '0;
  assign tx_data_TLAST  = emit && (beat_q == BW'(N_BEATS - 1));
  assign tx_count       = count_q;

`ifdef TOP_K_FRAME_STATS_EN
  logic [31:0] frame_id_q, frame_len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_id_q  <= '0;
      frame_len_q <= '0;
    end else if (last_hs) begin
      frame_id_q  <= frame_id_q + 1'b1;
      frame_len_q <= '0;
    end else if (!emit) begin
      if (clear) frame_len_q <= '0;
      else if (rx_data_TVALID && frame_len_q != '1) frame_len_q <= frame_len_q + 1'b1;
    end
  end

  assign tx_frame_id  = frame_id_q;
  assign tx_frame_len = frame_len_q;
`endif

endmodule

// File: tb/tb_top_k_stream_sorter.sv
// Directed bench for top_k_stream_sorter: three configurations, scoreboard of expected output beats.
module tb_top_k_stream_sorter;

  typedef struct {
    logic [511:0] dat;
    logic [15:0]  keep;
    logic         last;
    logic [7:0]   cnt;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, rx_last, tx_rdy;
  logic [31:0] rx_dat;
  logic        vld_a, vld_b, vld_c;

  logic         rr_a, tv_a, tl_a;  logic [511:0] td_a;  logic [15:0] tk_a;  logic [4:0] tc_a;
  logic         rr_b, tv_b, tl_b;  logic [127:0] td_b;  logic [3:0]  tk_b;  logic [2:0] tc_b;
  logic         rr_c, tv_c, tl_c;  logic [511:0] td_c;  logic [15:0] tk_c;  logic [4:0] tc_c;
`ifdef TOP_K_FRAME_STATS_EN
  logic [31:0] fid_a, flen_a, fid_b, flen_b, fid_c, flen_c;
`endif

  top_k_stream_sorter u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .rx_data_TVALID(vld_a), .rx_data_TREADY(rr_a), .rx_data_TDATA(rx_dat), .rx_data_TLAST(rx_last),
    .tx_data_TVALID(tv_a), .tx_data_TREADY(tx_rdy), .tx_data_TDATA(td_a), .tx_data_TKEEP(tk_a),
    .tx_data_TLAST(tl_a), .tx_count(tc_a)
`ifdef TOP_K_FRAME_STATS_EN
    , .tx_frame_id(fid_a), .tx_frame_len(flen_a)
`endif
  );

  top_k_stream_sorter #(.TOP_K_NUM(4), .INTEGER_SIZE(32), .OUT_WIDTH(128), .SIGNED(1), .DESCENDING(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .rx_data_TVALID(vld_b), .rx_data_TREADY(rr_b), .rx_data_TDATA(rx_dat), .rx_data_TLAST(rx_last),
    .tx_data_TVALID(tv_b), .tx_data_TREADY(tx_rdy), .tx_data_TDATA(td_b), .tx_data_TKEEP(tk_b),
    .tx_data_TLAST(tl_b), .tx_count(tc_b)
`ifdef TOP_K_FRAME_STATS_EN
    , .tx_frame_id(fid_b), .tx_frame_len(flen_b)
`endif
  );

  top_k_stream_sorter #(.TOP_K_NUM(20), .INTEGER_SIZE(32), .OUT_WIDTH(512)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .rx_data_TVALID(vld_c), .rx_data_TREADY(rr_c), .rx_data_TDATA(rx_dat), .rx_data_TLAST(rx_last),
    .tx_data_TVALID(tv_c), .tx_data_TREADY(tx_rdy), .tx_data_TDATA(td_c), .tx_data_TKEEP(tk_c),
    .tx_data_TLAST(tl_c), .tx_count(tc_c)
`ifdef TOP_K_FRAME_STATS_EN
    , .tx_frame_id(fid_c), .tx_frame_len(flen_c)
`endif
  );

  int           sel;
  logic         obs_vld, obs_rrdy, obs_last;
  logic [511:0] obs_dat;
  logic [15:0]  obs_keep;
  logic [7:0]   obs_cnt;

  always_comb begin
    obs_vld = 1'b0; obs_rrdy = 1'b0; obs_last = 1'b0;
    obs_dat = '0; obs_keep = '0; obs_cnt = '0;
    case (sel)
      0: begin
        obs_vld = tv_a; obs_rrdy = rr_a; obs_last = tl_a;
        obs_dat = td_a; obs_keep = tk_a; obs_cnt = 8'(tc_a);
      end
      1: begin
        obs_vld = tv_b; obs_rrdy = rr_b; obs_last = tl_b;
        obs_dat = 512'(td_b); obs_keep = 16'(tk_b); obs_cnt = 8'(tc_b);
      end
      default: begin
        obs_vld = tv_c; obs_rrdy = rr_c; obs_last = tl_c;
        obs_dat = td_c; obs_keep = tk_c; obs_cnt = 8'(tc_c);
      end
    endcase
  end

  int    tests_run = 0;
  int    tests_failed = 0;
  beat_t sb[$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit better(input logic [31:0] a, input logic [31:0] b, input bit sgn, input bit desc);
    if (sgn) return desc ? ($signed(a) > $signed(b)) : ($signed(a) < $signed(b));
    return desc ? (a > b) : (a < b);
  endfunction

  // Reference: stable selection of the best K of the whole frame, earliest value wins ties.
  task automatic push_expected(input int s, input logic [31:0] v[$]);
    int k, lanes, nb;
    bit sgn, desc;
    logic [31:0] rem[$];
    logic [31:0] ranks[$];
    case (s)
      0:       begin k = 16; lanes = 16; nb = 1; sgn = 0; desc = 1; end
      1:       begin k = 4;  lanes = 4;  nb = 1; sgn = 1; desc = 0; end
      default: begin k = 20; lanes = 16; nb = 2; sgn = 0; desc = 1; end
    endcase
    rem = v;
    while (ranks.size() < k && rem.size() > 0) begin
      int bi;
      bi = 0;
      for (int j = 1; j < rem.size(); j++) if (better(rem[j], rem[bi], sgn, desc)) bi = j;
      ranks.push_back(rem[bi]);
      rem.delete(bi);
    end
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      e.dat = '0; e.keep = '0;
      for (int l = 0; l < lanes; l++) begin
        if (b * lanes + l < ranks.size()) begin
          e.dat[l*32 +: 32] = ranks[b*lanes + l];
          e.keep[l] = 1'b1;
        end
      end
      e.last = (b == nb - 1);
      e.cnt  = 8'(ranks.size());
      sb.push_back(e);
    end
  endtask

  task automatic set_vld(input int s, input logic v);
    vld_a = (s == 0) & v;
    vld_b = (s == 1) & v;
    vld_c = (s == 2) & v;
  endtask

  task automatic drive_frame(input int s, input logic [31:0] v[$], input bit with_last);
    sel = s;
    if (with_last) push_expected(s, v);
    for (int i = 0; i < v.size(); i++) begin
      set_vld(s, 1'b1);
      rx_dat  = v[i];
      rx_last = with_last && (i == v.size() - 1);
      @(negedge clk);
      check("rx_ready_accum", 512'(obs_rrdy), 512'(1));
      @(posedge clk); #1;
    end
    set_vld(s, 1'b0);
    rx_last = 1'b0;
    if (with_last) begin
      check("tvalid_after_tlast", 512'(obs_vld), 512'(1));
      check("rx_ready_emit", 512'(obs_rrdy), 512'(0));
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (obs_vld && tx_rdy) begin
        beat_t e;
        e = sb.pop_front();
        check("rx_ready_emit_beat", 512'(obs_rrdy), 512'(0));
        check("beat_data", obs_dat, e.dat);
        check("beat_keep", 512'(obs_keep), 512'(e.keep));
        check("beat_last", 512'(obs_last), 512'(e.last));
        check("beat_count", 512'(obs_cnt), 512'(e.cnt));
      end
    end
    if (sb.size() > 0) check("drain_timeout", 512'(sb.size()), 512'(0));
    @(posedge clk); #1;
    check("back_to_accum_tvalid", 512'(obs_vld), 512'(0));
    check("back_to_accum_rx_ready", 512'(obs_rrdy), 512'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  logic [31:0]  vals[$];
  logic [511:0] snap_dat;
  logic [15:0]  snap_keep;
  logic [7:0]   snap_cnt;

  initial begin
    rst_n = 1'b0; clear = 1'b0; rx_dat = '0; rx_last = 1'b0; tx_rdy = 1'b1; sel = 0;
    set_vld(0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tvalid", 512'(obs_vld), 512'(0));
    check("rst_rx_ready", 512'(obs_rrdy), 512'(1));
    check("rst_count", 512'(obs_cnt), 512'(0));
    check("rst_keep", 512'(obs_keep), 512'(0));
    check("rst_data", obs_dat, 512'(0));
    check("rst_last", 512'(obs_last), 512'(0));
    @(posedge clk); #1;

    // 1..20 into K=16: top sixteen, descending
    vals.delete();
    for (int i = 1; i <= 20; i++) vals.push_back(32'(i));
    drive_frame(0, vals, 1'b1);
    check("full_lane0", 512'(obs_dat[31:0]), 512'(20));
    check("full_lane15", 512'(obs_dat[511:480]), 512'(5));
    drain(20);

    // short frame: empty ranks carry zero with keep cleared
    vals.delete(); vals.push_back(32'd5); vals.push_back(32'd9);
    drive_frame(0, vals, 1'b1);
    check("short_keep", 512'(obs_keep), 512'(16'h0003));
    drain(20);

    // signed ascending, K=4, duplicate minimum
    vals.delete();
    vals.push_back(32'hFFFF_FFFF); vals.push_back(32'd3); vals.push_back(32'hFFFF_FFF9);
    vals.push_back(32'd0);         vals.push_back(32'hFFFF_FFF9);
    drive_frame(1, vals, 1'b1);
    check("signed_rank0", 512'(obs_dat[31:0]), 512'(32'hFFFF_FFF9));
    check("signed_rank3", 512'(obs_dat[127:96]), 512'(0));
    drain(20);

    // K=20 over two beats with output stalled
    tx_rdy = 1'b0;
    vals.delete();
    for (int i = 0; i < 25; i++) vals.push_back(32'((i * 37) % 101 + 1));
    drive_frame(2, vals, 1'b1);
    snap_dat = obs_dat; snap_keep = obs_keep; snap_cnt = obs_cnt;
    check("stall_beat0_keep", 512'(obs_keep), 512'(16'hFFFF));
    repeat (5) begin
      @(negedge clk);
      check("stall_tvalid", 512'(obs_vld), 512'(1));
      check("stall_rx_ready", 512'(obs_rrdy), 512'(0));
      check("stall_data", obs_dat, snap_dat);
      check("stall_keep", 512'(obs_keep), 512'(snap_keep));
      check("stall_count", 512'(obs_cnt), 512'(snap_cnt));
    end
    @(posedge clk); #1;
    tx_rdy = 1'b1;
    drain(20);

    // abort mid-frame; a beat offered alongside clear is dropped
    vals.delete();
    for (int i = 0; i < 8; i++) vals.push_back(32'(100 + i));
    drive_frame(0, vals, 1'b0);
    vld_a = 1'b1; rx_dat = 32'd99; clear = 1'b1;
    @(posedge clk); #1;
    vld_a = 1'b0; clear = 1'b0;
    vals.delete(); vals.push_back(32'd42);
    drive_frame(0, vals, 1'b1);
    check("clear_count", 512'(obs_cnt), 512'(1));
    drain(20);

    // reset while a result is pending
    tx_rdy = 1'b0;
    vals.delete(); vals.push_back(32'd1); vals.push_back(32'd2); vals.push_back(32'd3);
    drive_frame(0, vals, 1'b1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_emit_tvalid", 512'(obs_vld), 512'(0));
    check("rst_emit_count", 512'(obs_cnt), 512'(0));
    check("rst_emit_keep", 512'(obs_keep), 512'(0));
    check("rst_emit_data", obs_dat, 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_rx_ready", 512'(obs_rrdy), 512'(1));
    tx_rdy = 1'b1;
    vals.delete(); vals.push_back(32'd7); vals.push_back(32'd3); vals.push_back(32'd11);
    drive_frame(0, vals, 1'b1);
`ifdef TOP_K_FRAME_STATS_EN
    check("stats_frame_id", 512'(fid_a), 512'(0));
    check("stats_frame_len", 512'(flen_a), 512'(3));
`endif
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
